// File: rtl/ex_stage_md.sv
// miniRV execute stage: single-cycle ALU/next-PC plus iterative RV32M unit,
// with a registered valid/ready result. States: IDLE | waiting for operands; BUSY | iterating.
module ex_stage_md #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_alua_sel,
  input  logic            in_alub_sel,
  input  logic [3:0]      in_alu_op,
  input  logic [1:0]      in_npc_op,
  input  logic            in_md_en,
  input  logic [2:0]      in_md_op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_pc4,
  output logic            out_jump,
  output logic [XLEN-1:0] out_npc,
  output logic            busy
);
  localparam int CW = $clog2(XLEN);
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_BEQ = 4'd10, ALU_BNE = 4'd11,
                         ALU_BLT = 4'd12, ALU_BGE = 4'd13, ALU_BLTU = 4'd14, ALU_BGEU = 4'd15;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [2*XLEN-1:0] p_q, p_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              out_valid_q, out_valid_d, out_jump_q, out_jump_d;
  logic [XLEN-1:0]   out_result_q, out_result_d, out_pc4_q, out_pc4_d, out_npc_q, out_npc_d;

  logic [XLEN-1:0] alu_a, alu_b, alu_c, pc4, br_tgt, npc;
  logic            alu_f, jump, accept;

  assign in_ready = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign pc4      = in_pc + XLEN'(4);
  assign br_tgt   = in_pc + in_imm;

  always_comb begin
    alu_a = in_alua_sel ? in_pc : in_rs1;
    alu_b = in_alub_sel ? in_imm : in_rs2;
    alu_c = '0;
    alu_f = 1'b0;
    case (in_alu_op)
      ALU_ADD:  alu_c = alu_a + alu_b;
      ALU_SUB:  alu_c = alu_a - alu_b;
      ALU_AND:  alu_c = alu_a & alu_b;
      ALU_OR:   alu_c = alu_a | alu_b;
      ALU_XOR:  alu_c = alu_a ^ alu_b;
      ALU_SLL:  alu_c = alu_a << alu_b[CW-1:0];
      ALU_SRL:  alu_c = alu_a >> alu_b[CW-1:0];
      ALU_SRA:  alu_c = $unsigned($signed(alu_a) >>> alu_b[CW-1:0]);
      ALU_SLT:  alu_c = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_c = {{(XLEN-1){1'b0}}, alu_a < alu_b};
      ALU_BEQ:  alu_f = (alu_a == alu_b);
      ALU_BNE:  alu_f = (alu_a != alu_b);
      ALU_BLT:  alu_f = ($signed(alu_a) < $signed(alu_b));
      ALU_BGE:  alu_f = ($signed(alu_a) >= $signed(alu_b));
      ALU_BLTU: alu_f = (alu_a < alu_b);
      ALU_BGEU: alu_f = (alu_a >= alu_b);
      default:  alu_c = '0;
    endcase
    jump = in_npc_op[1] || (in_npc_op[0] && alu_f);
    case (in_npc_op)
      2'b01:   npc = alu_f ? br_tgt : pc4;
      2'b10:   npc = br_tgt;
      2'b11:   npc = alu_c & ~XLEN'(1);
      default: npc = pc4;
    endcase
  end

  // Operand conditioning for the M unit: iterate on magnitudes, fix the sign at the end.
  logic              a_sgn, b_sgn, a_neg, b_neg, md_neg, div_zero, div_ovf, md_quick;
  logic [XLEN-1:0]   a_mag, b_mag, quick_res;
  logic [2*XLEN-1:0] fa, fb, fast_prod;

  always_comb begin
    a_sgn    = (in_md_op == 3'd1) || (in_md_op == 3'd2) || (in_md_op == 3'd4) || (in_md_op == 3'd6);
    b_sgn    = (in_md_op == 3'd1) || (in_md_op == 3'd4) || (in_md_op == 3'd6);
    a_neg    = a_sgn && in_rs1[XLEN-1];
    b_neg    = b_sgn && in_rs2[XLEN-1];
    a_mag    = a_neg ? -in_rs1 : in_rs1;
    b_mag    = b_neg ? -in_rs2 : in_rs2;
    md_neg   = (in_md_op[2] && in_md_op[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = in_md_op[2] && (in_rs2 == '0);
    div_ovf  = in_md_op[2] && !in_md_op[0] && (in_rs1 == XMIN) && (in_rs2 == '1);
    md_quick = div_zero || div_ovf || (FAST_MUL && !in_md_op[2]);
    fa        = {{XLEN{a_neg}}, in_rs1};
    fb        = {{XLEN{b_neg}}, in_rs2};
    fast_prod = fa * fb;
    if (div_zero)                quick_res = in_md_op[1] ? in_rs1 : '1;
    else if (div_ovf)            quick_res = in_md_op[1] ? '0 : XMIN;
    else if (in_md_op[1:0] == 0) quick_res = fast_prod[XLEN-1:0];
    else                         quick_res = fast_prod[2*XLEN-1:XLEN];
  end

  // One iteration: shift-add multiply (multiplier in p low half) or restoring divide step.
  logic [XLEN:0]     mul_sum, div_r, div_diff;
  logic [XLEN-1:0]   it_a, div_val;
  logic [2*XLEN-1:0] it_p, mul_full;
  logic [XLEN-1:0]   fin_res;

  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, a_q} : '0);
    div_r    = {p_q[XLEN-1:0], a_q[XLEN-1]};
    div_diff = div_r - {1'b0, b_q};
    if (op_q[2]) begin
      it_p = {p_q[2*XLEN-1:XLEN], div_diff[XLEN] ? div_r[XLEN-1:0] : div_diff[XLEN-1:0]};
      it_a = {a_q[XLEN-2:0], !div_diff[XLEN]};
    end else begin
      it_p = {mul_sum, p_q[XLEN-1:1]};
      it_a = a_q;
    end
    mul_full = neg_q ? -it_p : it_p;
    div_val  = op_q[1] ? it_p[XLEN-1:0] : it_a;
    if (op_q[2])                fin_res = neg_q ? -div_val : div_val;
    else if (op_q[1:0] == 2'd0) fin_res = mul_full[XLEN-1:0];
    else                        fin_res = mul_full[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    p_d          = p_q;
    op_d         = op_q;
    neg_d        = neg_q;
    out_valid_d  = out_valid_q && !out_ready;
    out_result_d = out_result_q;
    out_pc4_d    = out_pc4_q;
    out_jump_d   = out_jump_q;
    out_npc_d    = out_npc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          out_pc4_d = pc4;
          if (in_md_en) begin
            out_jump_d = 1'b0;
            out_npc_d  = pc4;
            if (md_quick) begin
              out_valid_d  = 1'b1;
              out_result_d = quick_res;
            end else begin
              state_d = BUSY;
              cnt_d   = CW'(XLEN-1);
              a_d     = a_mag;
              b_d     = b_mag;
              p_d     = in_md_op[2] ? '0 : {{XLEN{1'b0}}, b_mag};
              op_d    = in_md_op;
              neg_d   = md_neg;
            end
          end else begin
            out_valid_d  = 1'b1;
            out_result_d = in_npc_op[1] ? pc4 : alu_c;
            out_jump_d   = jump;
            out_npc_d    = npc;
          end
        end
      end
      BUSY: begin
        a_d   = it_a;
        p_d   = it_p;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d      = IDLE;
          cnt_d        = '0;
          out_valid_d  = 1'b1;
          out_result_d = fin_res;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      p_q          <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_pc4_q    <= '0;
      out_jump_q   <= 1'b0;
      out_npc_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      p_q          <= p_d;
      op_q         <= op_d;
      neg_q        <= neg_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_pc4_q    <= out_pc4_d;
      out_jump_q   <= out_jump_d;
      out_npc_q    <= out_npc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_pc4    = out_pc4_q;
  assign out_jump   = out_jump_q;
  assign out_npc    = out_npc_q;
  assign busy       = (state_q == BUSY);

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: iterative instance (dut) and FAST_MUL instance (dut_f).
module tb_ex_stage_md;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_valid_f, out_ready, out_ready_f;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
  logic        in_alua_sel, in_alub_sel, in_md_en;
  logic [3:0]  in_alu_op;
  logic [1:0]  in_npc_op;
  logic [2:0]  in_md_op;
  logic        in_ready, out_valid, out_jump, busy;
  logic [31:0] out_result, out_pc4, out_npc;
  logic        in_ready_f, out_valid_f, out_jump_f, busy_f;
  logic [31:0] out_result_f, out_pc4_f, out_npc_f;

  int n_chk = 0;
  int n_fail = 0;
  int lat, busy_cnt, stale;
  logic saw_rdy;

  always #5 clk = ~clk;

  ex_stage_md #(.XLEN(32), .FAST_MUL(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_alua_sel(in_alua_sel), .in_alub_sel(in_alub_sel), .in_alu_op(in_alu_op),
    .in_npc_op(in_npc_op), .in_md_en(in_md_en), .in_md_op(in_md_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_pc4(out_pc4), .out_jump(out_jump), .out_npc(out_npc), .busy(busy));

  ex_stage_md #(.XLEN(32), .FAST_MUL(1'b1)) dut_f (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid_f), .in_ready(in_ready_f),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_alua_sel(in_alua_sel), .in_alub_sel(in_alub_sel), .in_alu_op(in_alu_op),
    .in_npc_op(in_npc_op), .in_md_en(in_md_en), .in_md_op(in_md_op),
    .out_valid(out_valid_f), .out_ready(out_ready_f), .out_result(out_result_f),
    .out_pc4(out_pc4_f), .out_jump(out_jump_f), .out_npc(out_npc_f), .busy(busy_f));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic md, input logic [2:0] mop, input logic [3:0] aop,
                        input logic [1:0] nop, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] imm, input logic asel,
                        input logic bsel);
    in_md_en = md; in_md_op = mop; in_alu_op = aop; in_npc_op = nop;
    in_pc = pc; in_rs1 = r1; in_rs2 = r2; in_imm = imm;
    in_alua_sel = asel; in_alub_sel = bsel;
  endtask

  // Called #1 after an edge; returns #1 after the accepting edge.
  task automatic send_op();
    int n = 0;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) check_val("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int l);
    l = 1; busy_cnt = 0; saw_rdy = 1'b0;
    while (!out_valid && l < 100) begin
      if (busy) busy_cnt++;
      if (in_ready) saw_rdy = 1'b1;
      @(posedge clk); #1; l++;
    end
    if (!out_valid) check_val("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic run_md(input string tag, input logic [2:0] mop, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] exp, input int exp_lat);
    set_in(1'b1, mop, 4'd0, 2'b00, 32'h2000, r1, r2, 32'd0, 1'b0, 1'b0);
    send_op();
    wait_result(lat);
    check_val({tag, "_res"}, out_result, exp);
    check_val({tag, "_lat"}, lat, exp_lat);
  endtask

  task automatic run_fast(input string tag, input logic [2:0] mop, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] exp);
    set_in(1'b1, mop, 4'd0, 2'b00, 32'h2000, r1, r2, 32'd0, 1'b0, 1'b0);
    in_valid_f = 1'b1;
    @(posedge clk); #1;
    in_valid_f = 1'b0;
    check_val({tag, "_valid_lat1"}, {31'd0, out_valid_f}, 32'd1);
    check_val({tag, "_res"}, out_result_f, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid_f = 1'b0;
    out_ready = 1'b1; out_ready_f = 1'b1;
    set_in(1'b0, 3'd0, 4'd0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_result", out_result, 32'd0);
    check_val("rst_npc", out_npc, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    #1;
    check_val("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD
    set_in(1'b0, 3'd0, 4'd0, 2'b00, 32'h1000, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0);
    send_op();
    wait_result(lat);
    check_val("add_lat", lat, 32'd1);
    check_val("add_res", out_result, 32'd12);
    check_val("add_jump", {31'd0, out_jump}, 32'd0);
    check_val("add_npc", out_npc, 32'h1004);
    check_val("add_pc4", out_pc4, 32'h1004);

    // Iterative divide / multiply
    run_md("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    check_val("div_busy_cycles", busy_cnt, 32'd32);
    check_val("div_in_ready_low", {31'd0, saw_rdy}, 32'd0);
    run_md("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_md("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_md("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_md("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_md("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    run_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

    // Special cases, latency 1
    run_md("divu_by0", 3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    run_md("remu_by0", 3'd7, 32'd9, 32'd0, 32'd9, 1);
    run_md("div_by0", 3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1);
    run_md("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_md("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    check_val("md_jump", {31'd0, out_jump}, 32'd0);
    check_val("md_npc", out_npc, 32'h2004);

    // FAST_MUL instance
    @(posedge clk); #1;
    run_fast("f_mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_fast("f_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_fast("f_mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_fast("f_mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);

    // Back-pressure hold, then back-to-back stream
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_in(1'b0, 3'd0, 4'd0, 2'b00, 32'h3000, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    send_op();
    set_in(1'b0, 3'd0, 4'd1, 2'b00, 32'h4000, 32'd50, 32'd9, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("hold_valid", {31'd0, out_valid}, 32'd1);
      check_val("hold_res", out_result, 32'd3);
      check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_val("release_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 3'd0, 4'd0, 2'b00, 32'h5000, 32'(i * 10), 32'd1, 32'd0, 1'b0, 1'b0);
      in_valid = 1'b1;
      @(posedge clk); #1;
      check_val("b2b_valid", {31'd0, out_valid}, 32'd1);
      check_val("b2b_res", out_result, 32'(i * 10 + 1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_val("b2b_drain", {31'd0, out_valid}, 32'd0);

    // flush mid-BUSY
    set_in(1'b1, 3'd5, 4'd0, 2'b00, 32'h6000, 32'd100, 32'd3, 32'd0, 1'b0, 1'b0);
    send_op();
    repeat (5) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_val("flush_busy", {31'd0, busy}, 32'd0);
    check_val("flush_valid", {31'd0, out_valid}, 32'd0);
    check_val("flush_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) stale++; end
    check_val("flush_no_stale", stale, 32'd0);

    // flush with same-cycle accept
    set_in(1'b0, 3'd0, 4'd0, 2'b00, 32'h6100, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0);
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_val("flush_accept_dropped", {31'd0, out_valid}, 32'd0);

    // rst mid-BUSY
    set_in(1'b1, 3'd4, 4'd0, 2'b00, 32'h7000, 32'd77, 32'd5, 32'd0, 1'b0, 1'b0);
    send_op();
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_val("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rst_mid_busy", {31'd0, busy}, 32'd0);
    check_val("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_mid_result", out_result, 32'd0);
    stale = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) stale++; end
    check_val("rst_no_stale", stale, 32'd0);

    // Jumps and branches
    set_in(1'b0, 3'd0, 4'd0, 2'b11, 32'h100, 32'h203, 32'd0, 32'd0, 1'b0, 1'b1);
    send_op();
    wait_result(lat);
    check_val("jalr_npc", out_npc, 32'h202);
    check_val("jalr_res", out_result, 32'h104);
    check_val("jalr_jump", {31'd0, out_jump}, 32'd1);
    set_in(1'b0, 3'd0, 4'd0, 2'b10, 32'h200, 32'd0, 32'd0, 32'hFFFF_FFF8, 1'b1, 1'b1);
    send_op();
    wait_result(lat);
    check_val("jal_npc", out_npc, 32'h1F8);
    check_val("jal_res", out_result, 32'h204);
    set_in(1'b0, 3'd0, 4'd10, 2'b01, 32'h40, 32'd5, 32'd5, 32'h10, 1'b0, 1'b0);
    send_op();
    wait_result(lat);
    check_val("beq_jump", {31'd0, out_jump}, 32'd1);
    check_val("beq_npc", out_npc, 32'h50);
    set_in(1'b0, 3'd0, 4'd11, 2'b01, 32'h40, 32'd5, 32'd5, 32'h10, 1'b0, 1'b0);
    send_op();
    wait_result(lat);
    check_val("bne_jump", {31'd0, out_jump}, 32'd0);
    check_val("bne_npc", out_npc, 32'h44);
    set_in(1'b0, 3'd0, 4'd7, 2'b00, 32'h40, 32'h8000_0010, 32'd4, 32'd0, 1'b0, 1'b0);
    send_op();
    wait_result(lat);
    check_val("sra_res", out_result, 32'hF800_0001);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
